// File: rtl/cpu_types_pkg.sv
// Datapath-wide word and register-index types shared by the pipeline stages.
package cpu_types_pkg;

   localparam int unsigned WordW = 32;
   localparam int unsigned RegW  = 5;

   typedef logic [WordW-1:0] word_t;
   typedef logic [RegW-1:0]  regbits_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Mux-select encodings and small FSM state types used across the datapath stages.
package data_path_muxs_pkg;

   typedef enum logic [1:0] {
      RegDestRd = 2'd0,
      RegDestRt = 2'd1,
      RegDestRa = 2'd2
   } reg_dest_mux_selection;

   typedef enum logic [1:0] {
      MemIdle = 2'd0,
      MemBusy = 2'd1,
      MemDone = 2'd2
   } mem_state_t;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: remembers the word address of the last LL and reports a match.
module llsc_link_reg
   import cpu_types_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  set_i,
   input  logic  inval_i,
   input  logic  store_i,
   input  word_t addr_i,
   output logic  match_o
);

   logic  valid_q, valid_d;
   word_t addr_q, addr_d;

   assign match_o = valid_q & (addr_q == addr_i);

   // A new LL wins over a same-cycle invalidate: it re-arms the link afterwards.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (inval_i | (store_i & match_o)) begin
         valid_d = 1'b0;
      end
      if (set_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: data-cache handshake, stall generation, write-back latch.
// Define MEM_LLSC_EN to build in the LL/SC link register.
module mem_wb_stage
   import cpu_types_pkg::*;
   import data_path_muxs_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  word_t                 result_EX_MEM,
   input  word_t                 dmemstore_EX_MEM,
   input  logic                  dmemREN,
   input  logic                  dmemWEN,
   input  logic                  is_ll,
   input  logic                  is_sc,
   input  logic                  WEN_EX_MEM,
   input  reg_dest_mux_selection reg_dest_EX_MEM,
   input  regbits_t              Rt_EX_MEM,
   input  regbits_t              Rd_EX_MEM,
   input  logic                  halt_EX_MEM,
   input  word_t                 imemaddr_EX_MEM,
   input  word_t                 next_imemaddr_EX_MEM,
   output logic                  dREN,
   output logic                  dWEN,
   output word_t                 daddr,
   output word_t                 dstore,
   input  logic                  dhit,
   input  word_t                 dload,
   input  logic                  link_inval,
   input  logic                  enable_MEM_WB,
   input  logic                  flush_MEM_WB,
   output logic                  stall_mem,
   output logic                  WEN_MEM_WB,
   output logic                  halt_MEM_WB,
   output reg_dest_mux_selection reg_dest_MEM_WB,
   output regbits_t              Rt_MEM_WB,
   output regbits_t              Rd_MEM_WB,
   output word_t                 result_MEM_WB,
   output word_t                 dload_MEM_WB,
   output word_t                 next_imemaddr_MEM_WB,
   output word_t                 imemaddr_MEM_WB
);

   mem_state_t state_q, state_d;
   word_t      hold_q, hold_d;

   logic  mem_op, pending, hit, sc_fail, load_en;
   word_t result_sel, dload_sel;

   logic                  wen_q, halt_q;
   reg_dest_mux_selection reg_dest_q;
   regbits_t              rt_q, rd_q;
   word_t                 result_q, dload_q, next_pc_q, pc_q;

   assign mem_op    = dmemREN | dmemWEN;
   assign pending   = mem_op & (state_q != MemDone) & ~sc_fail;
   assign hit       = pending & dhit;
   assign dREN      = dmemREN & pending;
   assign dWEN      = dmemWEN & pending;
   assign daddr     = result_EX_MEM;
   assign dstore    = dmemstore_EX_MEM;
   assign stall_mem = pending & ~dhit;
   assign load_en   = enable_MEM_WB & ~stall_mem;

`ifdef MEM_LLSC_EN
   logic link_match;

   // In MemDone the SC has already been issued, so it can no longer fail even though
   // its own store has cleared the link.
   assign sc_fail = is_sc & ~link_match & (state_q != MemDone);

   llsc_link_reg u_link (
      .clk_i   (CLK),
      .rst_i   (RST),
      .set_i   (is_ll & dREN & dhit),
      .inval_i (link_inval),
      .store_i (dWEN & dhit),
      .addr_i  (result_EX_MEM),
      .match_o (link_match)
   );
`else
   logic unused_llsc;

   assign sc_fail     = 1'b0;
   assign unused_llsc = ^{is_ll, link_inval};
`endif

   assign result_sel = is_sc ? {{(WordW-1){1'b0}}, ~sc_fail} : result_EX_MEM;
   assign dload_sel  = hit ? dload : ((state_q == MemDone) ? hold_q : '0);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (flush_MEM_WB) begin
         state_d = MemIdle;
      end else begin
         case (state_q)
            MemIdle, MemBusy: begin
               if (pending & ~dhit) begin
                  state_d = MemBusy;
               end else if (hit & ~enable_MEM_WB) begin
                  state_d = MemDone;
                  hold_d  = dload;
               end else begin
                  state_d = MemIdle;
               end
            end
            MemDone: begin
               if (enable_MEM_WB) begin
                  state_d = MemIdle;
               end
            end
            default: state_d = MemIdle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= MemIdle;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // halt_q is sticky: neither flush nor a later non-halt op can clear it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wen_q      <= 1'b0;
         halt_q     <= 1'b0;
         reg_dest_q <= RegDestRd;
         rt_q       <= '0;
         rd_q       <= '0;
         result_q   <= '0;
         dload_q    <= '0;
         next_pc_q  <= '0;
         pc_q       <= '0;
      end else if (flush_MEM_WB) begin
         wen_q      <= 1'b0;
         reg_dest_q <= RegDestRd;
         rt_q       <= '0;
         rd_q       <= '0;
         result_q   <= '0;
         dload_q    <= '0;
         next_pc_q  <= '0;
         pc_q       <= '0;
      end else if (load_en) begin
         wen_q      <= WEN_EX_MEM;
         halt_q     <= halt_q | halt_EX_MEM;
         reg_dest_q <= reg_dest_EX_MEM;
         rt_q       <= Rt_EX_MEM;
         rd_q       <= Rd_EX_MEM;
         result_q   <= result_sel;
         dload_q    <= dload_sel;
         next_pc_q  <= next_imemaddr_EX_MEM;
         pc_q       <= imemaddr_EX_MEM;
      end
   end

   assign WEN_MEM_WB           = wen_q;
   assign halt_MEM_WB          = halt_q;
   assign reg_dest_MEM_WB      = reg_dest_q;
   assign Rt_MEM_WB            = rt_q;
   assign Rd_MEM_WB            = rd_q;
   assign result_MEM_WB        = result_q;
   assign dload_MEM_WB         = dload_q;
   assign next_imemaddr_MEM_WB = next_pc_q;
   assign imemaddr_MEM_WB      = pc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a transaction model.
// Builds with or without MEM_LLSC_EN.
module tb_mem_wb_stage;
   import cpu_types_pkg::*;
   import data_path_muxs_pkg::*;

`ifdef MEM_LLSC_EN
   localparam bit Llsc = 1'b1;
`else
   localparam bit Llsc = 1'b0;
`endif

   logic                  CLK, RST;
   word_t                 result_EX_MEM, dmemstore_EX_MEM, imemaddr_EX_MEM, next_imemaddr_EX_MEM;
   logic                  dmemREN, dmemWEN, is_ll, is_sc, WEN_EX_MEM, halt_EX_MEM;
   reg_dest_mux_selection reg_dest_EX_MEM, reg_dest_MEM_WB;
   regbits_t              Rt_EX_MEM, Rd_EX_MEM, Rt_MEM_WB, Rd_MEM_WB;
   logic                  dREN, dWEN, dhit, link_inval, enable_MEM_WB, flush_MEM_WB, stall_mem;
   word_t                 daddr, dstore, dload;
   logic                  WEN_MEM_WB, halt_MEM_WB;
   word_t                 result_MEM_WB, dload_MEM_WB, next_imemaddr_MEM_WB, imemaddr_MEM_WB;

   int n_checks = 0;
   int n_errors = 0;

   mem_wb_stage dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .result_EX_MEM        (result_EX_MEM),
      .dmemstore_EX_MEM     (dmemstore_EX_MEM),
      .dmemREN              (dmemREN),
      .dmemWEN              (dmemWEN),
      .is_ll                (is_ll),
      .is_sc                (is_sc),
      .WEN_EX_MEM           (WEN_EX_MEM),
      .reg_dest_EX_MEM      (reg_dest_EX_MEM),
      .Rt_EX_MEM            (Rt_EX_MEM),
      .Rd_EX_MEM            (Rd_EX_MEM),
      .halt_EX_MEM          (halt_EX_MEM),
      .imemaddr_EX_MEM      (imemaddr_EX_MEM),
      .next_imemaddr_EX_MEM (next_imemaddr_EX_MEM),
      .dREN                 (dREN),
      .dWEN                 (dWEN),
      .daddr                (daddr),
      .dstore               (dstore),
      .dhit                 (dhit),
      .dload                (dload),
      .link_inval           (link_inval),
      .enable_MEM_WB        (enable_MEM_WB),
      .flush_MEM_WB         (flush_MEM_WB),
      .stall_mem            (stall_mem),
      .WEN_MEM_WB           (WEN_MEM_WB),
      .halt_MEM_WB          (halt_MEM_WB),
      .reg_dest_MEM_WB      (reg_dest_MEM_WB),
      .Rt_MEM_WB            (Rt_MEM_WB),
      .Rd_MEM_WB            (Rd_MEM_WB),
      .result_MEM_WB        (result_MEM_WB),
      .dload_MEM_WB         (dload_MEM_WB),
      .next_imemaddr_MEM_WB (next_imemaddr_MEM_WB),
      .imemaddr_MEM_WB      (imemaddr_MEM_WB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an op is "done" once the cache has answered but WB has not yet taken it.
   typedef struct packed {
      logic        wen;
      logic        halt;
      logic [1:0]  rdest;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] dl;
      logic [31:0] npc;
      logic [31:0] pc;
   } wb_t;

   wb_t   m_wb = '0, m_wb_n = '0;
   bit    m_done = 0, m_done_n = 0, m_lv = 0, m_lv_n = 0;
   bit    m_consumed = 1, m_consumed_n = 1;
   word_t m_hold = '0, m_hold_n = '0, m_la = '0, m_la_n = '0;
   bit    chk_en = 0;

   always @(negedge CLK) begin : compare
      bit link_ok, scf, req, hit, load;
      link_ok = m_lv && (m_la == result_EX_MEM);
      scf     = Llsc && is_sc && !m_done && !link_ok;
      req     = (dmemREN || dmemWEN) && !m_done && !scf;
      hit     = req && dhit;
      if (chk_en) begin
         chk("dREN", dREN, dmemREN && req);
         chk("dWEN", dWEN, dmemWEN && req);
         chk("daddr", daddr, result_EX_MEM);
         chk("dstore", dstore, dmemstore_EX_MEM);
         chk("stall_mem", stall_mem, req && !dhit);
         chk("WEN_MEM_WB", WEN_MEM_WB, m_wb.wen);
         chk("halt_MEM_WB", halt_MEM_WB, m_wb.halt);
         chk("reg_dest_MEM_WB", reg_dest_MEM_WB, m_wb.rdest);
         chk("Rt_MEM_WB", Rt_MEM_WB, m_wb.rt);
         chk("Rd_MEM_WB", Rd_MEM_WB, m_wb.rd);
         chk("result_MEM_WB", result_MEM_WB, m_wb.res);
         chk("dload_MEM_WB", dload_MEM_WB, m_wb.dl);
         chk("next_imemaddr_MEM_WB", next_imemaddr_MEM_WB, m_wb.npc);
         chk("imemaddr_MEM_WB", imemaddr_MEM_WB, m_wb.pc);
      end
      m_wb_n   = m_wb;
      m_done_n = m_done;
      m_hold_n = m_hold;
      m_lv_n   = m_lv;
      m_la_n   = m_la;
      if (RST) begin
         m_wb_n       = '0;
         m_done_n     = 0;
         m_hold_n     = '0;
         m_lv_n       = 0;
         m_la_n       = '0;
         m_consumed_n = 1;
      end else begin
         load = enable_MEM_WB && !(req && !dhit);
         if (flush_MEM_WB) begin
            m_wb_n      = '0;
            m_wb_n.halt = m_wb.halt;
            m_done_n    = 0;
         end else if (load) begin
            m_wb_n.wen   = WEN_EX_MEM;
            m_wb_n.halt  = m_wb.halt || halt_EX_MEM;
            m_wb_n.rdest = reg_dest_EX_MEM;
            m_wb_n.rt    = Rt_EX_MEM;
            m_wb_n.rd    = Rd_EX_MEM;
            m_wb_n.res   = is_sc ? {31'b0, !scf} : result_EX_MEM;
            m_wb_n.dl    = hit ? dload : (m_done ? m_hold : 32'h0);
            m_wb_n.npc   = next_imemaddr_EX_MEM;
            m_wb_n.pc    = imemaddr_EX_MEM;
            m_done_n     = 0;
         end else if (hit) begin
            m_done_n = 1;
            m_hold_n = dload;
         end
         m_consumed_n = flush_MEM_WB || load;
         if (Llsc) begin
            if (link_inval || (dmemWEN && hit && link_ok)) m_lv_n = 0;
            if (is_ll && dmemREN && hit) begin
               m_lv_n = 1;
               m_la_n = result_EX_MEM;
            end
         end
      end
   end

   always @(posedge CLK) begin
      m_wb       = m_wb_n;
      m_done     = m_done_n;
      m_hold     = m_hold_n;
      m_lv       = m_lv_n;
      m_la       = m_la_n;
      m_consumed = m_consumed_n;
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle_inputs();
      result_EX_MEM        = '0;
      dmemstore_EX_MEM     = '0;
      dmemREN              = 0;
      dmemWEN              = 0;
      is_ll                = 0;
      is_sc                = 0;
      WEN_EX_MEM           = 0;
      reg_dest_EX_MEM      = RegDestRd;
      Rt_EX_MEM            = '0;
      Rd_EX_MEM            = '0;
      halt_EX_MEM          = 0;
      imemaddr_EX_MEM      = '0;
      next_imemaddr_EX_MEM = '0;
      dhit                 = 0;
      dload                = '0;
      link_inval           = 0;
      enable_MEM_WB        = 1;
      flush_MEM_WB         = 0;
   endtask

   task automatic new_instr();
      int    kind;
      word_t addrs [4];
      kind  = int'($urandom % 6);
      addrs = '{32'h200, 32'h204, 32'h300, $urandom};
      result_EX_MEM        = addrs[$urandom % 4];
      dmemstore_EX_MEM     = $urandom;
      dmemREN              = (kind == 1) || (kind == 2) || (kind == 4);
      dmemWEN              = (kind == 3) || (kind == 5);
      is_ll                = (kind == 4);
      is_sc                = (kind == 5);
      WEN_EX_MEM           = 1'($urandom);
      reg_dest_EX_MEM      = reg_dest_mux_selection'(2'($urandom_range(0, 2)));
      Rt_EX_MEM            = 5'($urandom);
      Rd_EX_MEM            = 5'($urandom);
      halt_EX_MEM          = ($urandom % 64) == 0;
      imemaddr_EX_MEM      = $urandom;
      next_imemaddr_EX_MEM = $urandom;
   endtask

   initial begin
      RST = 1;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #2;
      chk_en = 1;
      #2;
      chk("rst_WEN", WEN_MEM_WB, 0);
      chk("rst_result", result_MEM_WB, 0);
      chk("rst_halt", halt_MEM_WB, 0);
      chk("rst_dREN", dREN, 0);
      chk("rst_stall", stall_mem, 0);

      // Load miss answered on the third cycle.
      step(); RST = 0;
      dmemREN = 1; result_EX_MEM = 32'h100; WEN_EX_MEM = 1; Rt_EX_MEM = 5'd7;
      reg_dest_EX_MEM = RegDestRt;
      #2;
      chk("ld_stall0", stall_mem, 1);
      chk("ld_dREN0", dREN, 1);
      chk("ld_daddr", daddr, 32'h100);
      step(); #2;
      chk("ld_stall1", stall_mem, 1);
      step(); dhit = 1; dload = 32'hDEADBEEF; #2;
      chk("ld_stall2", stall_mem, 0);
      step(); idle_inputs(); #2;
      chk("ld_dload", dload_MEM_WB, 32'hDEADBEEF);
      chk("ld_result", result_MEM_WB, 32'h100);
      chk("ld_rt", Rt_MEM_WB, 32'd7);

      // Store hit while WB is frozen for two cycles.
      step();
      dmemWEN = 1; result_EX_MEM = 32'h40; dmemstore_EX_MEM = 32'h1234; WEN_EX_MEM = 0;
      enable_MEM_WB = 0; dhit = 1;
      #2;
      chk("st_dWEN0", dWEN, 1);
      chk("st_stall0", stall_mem, 0);
      chk("st_dstore", dstore, 32'h1234);
      step(); dhit = 0; #2;
      chk("st_dWEN1", dWEN, 0);
      step(); #2;
      chk("st_dWEN2", dWEN, 0);
      chk("st_held", result_MEM_WB, 0);
      step(); enable_MEM_WB = 1; #2;
      chk("st_dWEN3", dWEN, 0);
      step(); idle_inputs(); #2;
      chk("st_result", result_MEM_WB, 32'h40);

      // Flush wins over enable.
      step(); WEN_EX_MEM = 1; result_EX_MEM = 32'h55;
      step(); #2;
      chk("pre_fl_WEN", WEN_MEM_WB, 1);
      flush_MEM_WB = 1;
      step(); idle_inputs(); #2;
      chk("fl_WEN", WEN_MEM_WB, 0);
      chk("fl_result", result_MEM_WB, 0);

      // Sticky halt survives flush and later ops, cleared only by reset.
      step(); halt_EX_MEM = 1;
      step(); halt_EX_MEM = 0; flush_MEM_WB = 1; #2;
      chk("halt_set", halt_MEM_WB, 1);
      step(); flush_MEM_WB = 0; #2;
      chk("halt_flush", halt_MEM_WB, 1);
      step(); #2;
      chk("halt_sticky", halt_MEM_WB, 1);
      RST = 1;
      step(); RST = 0; #2;
      chk("halt_rst", halt_MEM_WB, 0);

      // Reset in the middle of a miss.
      step(); dmemREN = 1; result_EX_MEM = 32'h80; WEN_EX_MEM = 1;
      step(); #2;
      chk("rb_stall", stall_mem, 1);
      RST = 1; #1;
      chk("rb_dREN_in_rst", dREN, 1);
      step(); RST = 0; idle_inputs(); #2;
      chk("rb_dREN", dREN, 0);
      chk("rb_stall_after", stall_mem, 0);
      chk("rb_result", result_MEM_WB, 0);

      // Stray dhit with nothing outstanding.
      step(); dhit = 1; dload = 32'hCAFE; #2;
      chk("nop_stall", stall_mem, 0);
      step(); idle_inputs(); #2;
      chk("nop_dload", dload_MEM_WB, 0);

`ifdef MEM_LLSC_EN
      step(); dmemREN = 1; is_ll = 1; result_EX_MEM = 32'h200; dhit = 1; dload = 32'h7;
      step(); idle_inputs(); dmemWEN = 1; is_sc = 1; result_EX_MEM = 32'h200; dhit = 1; #2;
      chk("sc_dWEN", dWEN, 1);
      step(); idle_inputs(); #2;
      chk("sc_ok", result_MEM_WB, 1);
      step(); dmemREN = 1; is_ll = 1; result_EX_MEM = 32'h200; dhit = 1;
      step(); idle_inputs(); link_inval = 1;
      step(); idle_inputs(); dmemWEN = 1; is_sc = 1; result_EX_MEM = 32'h200; #2;
      chk("scf_dWEN", dWEN, 0);
      chk("scf_stall", stall_mem, 0);
      step(); idle_inputs(); #2;
      chk("scf_result", result_MEM_WB, 0);
`else
      step(); dmemWEN = 1; is_sc = 1; result_EX_MEM = 32'h300; dhit = 1; #2;
      chk("sc_dWEN", dWEN, 1);
      step(); idle_inputs(); #2;
      chk("sc_plain", result_MEM_WB, 1);
`endif

      for (int c = 0; c < 4000; c++) begin
         step();
         if (m_consumed) new_instr();
         dhit          = ($urandom % 3) == 0;
         dload         = $urandom;
         enable_MEM_WB = ($urandom % 5) != 0;
         flush_MEM_WB  = ($urandom % 23) == 0;
         link_inval    = ($urandom % 29) == 0;
         RST           = ($urandom % 250) == 0;
      end
      step();
      idle_inputs();
      RST = 0;
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
